// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared types and default timing constants for the button
//               press decoder: power/menu classifier state encoding and the
//               default debounce / long-press cycle counts (100 MHz clock).
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

  // 20 ms and 3 s at 100 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT   = 2000000;
  localparam int LONG_PRESS_CYCLES_DEFAULT = 300000000;

  // Encoding 2'd3 is unused and treated as illegal by the classifier.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESSED    = 2'd1,
    LONG_FIRED = 2'd2
  } press_state_e;

endpackage : button_pkg
`default_nettype wire

// File: rtl/button_press_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : button_press_decoder_if
// Description : Button bundle between the front-panel buttons and the
//               decoder. Raw buttons flow into the decoder; single-cycle
//               press pulses and the classifier debug state flow out.
//   btn_power_menu, btn_first, btn_second, btn_third, btn_self_clean
//                 : raw, bouncing, active-high, asynchronous buttons
//   power_menu_short_press / power_menu_long_press : classification pulses
//   first/second/third_level_press, self_clean_press : press pulses
//   press_state   : power/menu classifier state (debug)
//   Modports: master = button/consumer side, slave = decoder side.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_press_decoder_if;
  import button_pkg::*;

  logic         btn_power_menu;
  logic         btn_first;
  logic         btn_second;
  logic         btn_third;
  logic         btn_self_clean;

  logic         power_menu_short_press;
  logic         power_menu_long_press;
  logic         first_level_press;
  logic         second_level_press;
  logic         third_level_press;
  logic         self_clean_press;
  press_state_e press_state;

  modport master (
    output btn_power_menu, btn_first, btn_second, btn_third, btn_self_clean,
    input  power_menu_short_press, power_menu_long_press,
    input  first_level_press, second_level_press, third_level_press,
    input  self_clean_press, press_state
  );

  modport slave (
    input  btn_power_menu, btn_first, btn_second, btn_third, btn_self_clean,
    output power_menu_short_press, power_menu_long_press,
    output first_level_press, second_level_press, third_level_press,
    output self_clean_press, press_state
  );

endinterface : button_press_decoder_if
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : 2-flop synchronizer followed by a stability-count debouncer.
//               The debounced level follows the synchronized input only
//               after it has differed from the current level for
//               DEBOUNCE_CYCLES consecutive samples.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_raw    : raw asynchronous button input
//   level      : debounced level
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  btn_raw,
  output logic level
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Any sample that agrees with the current level restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule : button_debouncer
`default_nettype wire

// File: rtl/button_press_decoder.sv
`default_nettype none
// ============================================================================
// Module      : button_press_decoder
// Description : Debounces five front-panel buttons, emits one-cycle press
//               pulses for the level/self-clean buttons and classifies the
//               power/menu button as a short or long press.
//   clk, rst_n : clock (100 MHz), asynchronous active-low reset
//   bus        : button_press_decoder_if.slave (raw buttons in, pulses and
//                press_state out); all outputs are registered.
//   Optional   : BUTTON_LEVEL_LOCKOUT_EN - when defined, level/self-clean
//                pulses are suppressed while press_state is not IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module button_press_decoder
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT
) (
  input  wire                    clk,
  input  wire                    rst_n,
  button_press_decoder_if.slave  bus
);

  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  // Bit map: 0 power/menu, 1 first, 2 second, 3 third, 4 self-clean.
  logic [4:0] raw_btn;
  logic [4:0] level;
  logic [4:0] level_prev_q, level_prev_d;
  logic [4:0] rise;
  logic [3:0] press_q, press_d;
  logic       level_enable;

  press_state_e      state_q;
  logic [HOLD_W-1:0] hold_q;
  logic              short_q;
  logic              long_q;

  assign raw_btn = {bus.btn_self_clean, bus.btn_third, bus.btn_second,
                    bus.btn_first, bus.btn_power_menu};

  for (genvar i = 0; i < 5; i++) begin : g_debounce
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (raw_btn[i]),
      .level   (level[i])
    );
  end

  assign rise = level & ~level_prev_q;

`ifdef BUTTON_LEVEL_LOCKOUT_EN
  assign level_enable = (state_q == IDLE);
`else
  assign level_enable = 1'b1;
`endif

  always_comb begin
    level_prev_d = level;
    press_d      = rise[4:1] & {4{level_enable}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev_q <= '0;
      press_q      <= '0;
    end else begin
      level_prev_q <= level_prev_d;
      press_q      <= press_d;
    end
  end

  // Power/menu classifier. Long press fires while still held; a release in
  // LONG_FIRED is silent, so each press yields at most one pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      short_q <= 1'b0;
      long_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise[0]) begin
            state_q <= PRESSED;
            hold_q  <= '0;
          end
        end
        PRESSED: begin
          if (!level[0]) begin
            short_q <= 1'b1;
            state_q <= IDLE;
          end else if (hold_q == HOLD_LAST) begin
            long_q  <= 1'b1;
            state_q <= LONG_FIRED;
          end else if (hold_q != '1) begin
            hold_q  <= hold_q + HOLD_W'(1);
          end
        end
        LONG_FIRED: begin
          if (!level[0]) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.power_menu_short_press = short_q;
  assign bus.power_menu_long_press  = long_q;
  assign bus.first_level_press      = press_q[0];
  assign bus.second_level_press     = press_q[1];
  assign bus.third_level_press      = press_q[2];
  assign bus.self_clean_press       = press_q[3];
  assign bus.press_state            = state_q;

endmodule : button_press_decoder
`default_nettype wire

// File: tb/tb_button_press_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_press_decoder
// Description : Self-checking bench for button_press_decoder with
//               DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20. Expected pulses
//               (signal, cycle) are queued when stimulus is applied and
//               retired by a negedge monitor as the DUT pulses.
//               Honours BUTTON_LEVEL_LOCKOUT_EN for the lockout scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_press_decoder;
  import button_pkg::*;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int LAT  = DEB + 3;   // drive cycle -> pulse cycle

  // Pulse indices
  localparam int S_SHORT = 0;
  localparam int S_FIRST = 1;
  localparam int S_SECOND = 2;
  localparam int S_THIRD = 3;
  localparam int S_SELF  = 4;
  localparam int S_LONG  = 5;

  typedef struct {
    int sig;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  exp_t exp_q[$];

  button_press_decoder_if bus_if ();

  button_press_decoder #(
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic string sig_name(input int s);
    case (s)
      S_SHORT:  return "power_menu_short_press";
      S_FIRST:  return "first_level_press";
      S_SECOND: return "second_level_press";
      S_THIRD:  return "third_level_press";
      S_SELF:   return "self_clean_press";
      default:  return "power_menu_long_press";
    endcase
  endfunction

  function automatic logic [5:0] pulses();
    return {bus_if.power_menu_long_press, bus_if.self_clean_press,
            bus_if.third_level_press, bus_if.second_level_press,
            bus_if.first_level_press, bus_if.power_menu_short_press};
  endfunction

  // Scoreboard monitor: every observed pulse must retire a matching entry.
  always @(negedge clk) begin
    logic [5:0] p;
    int idx;
    if (rst_n) begin
      p = pulses();
      for (int s = 0; s < 6; s++) begin
        if (p[s]) begin
          idx = -1;
          for (int k = 0; k < exp_q.size(); k++)
            if (idx < 0 && exp_q[k].sig == s && exp_q[k].cyc == cyc) idx = k;
          n_cmp++;
          if (idx < 0) begin
            n_err++;
            $display("FAIL %s at cycle %0d: observed 1, required 0",
                     sig_name(s), cyc);
          end else begin
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 1000) begin
      step(1);
      guard++;
    end
  endtask

  task automatic push(input int s, input int c);
    exp_t e;
    e.sig = s;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.btn_power_menu = 1'b0;
    bus_if.btn_first      = 1'b0;
    bus_if.btn_second     = 1'b0;
    bus_if.btn_third      = 1'b0;
    bus_if.btn_self_clean = 1'b0;
    step(3);
    @(negedge clk);
    n_cmp++;
    if (pulses() !== 6'b0) begin
      n_err++;
      $display("FAIL reset_pulses: observed %b, required 000000", pulses());
    end
    n_cmp++;
    if (bus_if.press_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: observed %0d, required 0", bus_if.press_state);
    end
    step(1);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_first_press();
    int n;
    n = cyc;
    bus_if.btn_first = 1'b1;
    push(S_FIRST, n + LAT);
    step(20);
    bus_if.btn_first = 1'b0;
    step(15);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL first_press missing: observed %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_bounce();
    int n;
    for (int i = 0; i < 10; i++) begin
      bus_if.btn_second = (i % 2 == 0);
      step(2);
    end
    n = cyc;
    bus_if.btn_second = 1'b1;
    push(S_SECOND, n + LAT);
    step(15);
    bus_if.btn_second = 1'b0;
    step(15);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL bounce missing: observed %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_short_press();
    int n;
    int r;
    n = cyc;
    bus_if.btn_power_menu = 1'b1;
    wait_cyc(n + LAT + 1);
    @(negedge clk);
    n_cmp++;
    if (bus_if.press_state !== PRESSED) begin
      n_err++;
      $display("FAIL short_state_pressed: observed %0d, required 1", bus_if.press_state);
    end
    wait_cyc(n + 10);
    r = cyc;
    bus_if.btn_power_menu = 1'b0;
    push(S_SHORT, r + LAT);
    step(15);
    @(negedge clk);
    n_cmp++;
    if (bus_if.press_state !== IDLE || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL short_press: observed state %0d pending %0d, required state 0 pending 0",
               bus_if.press_state, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_long_press();
    int n;
    int r;
    n = cyc;
    bus_if.btn_power_menu = 1'b1;
    push(S_LONG, n + LAT + LONG);
    wait_cyc(n + LAT + 1);
    @(negedge clk);
    n_cmp++;
    if (bus_if.press_state !== PRESSED) begin
      n_err++;
      $display("FAIL long_state_1: observed %0d, required 1", bus_if.press_state);
    end
    wait_cyc(n + LAT + LONG - 1);
    @(negedge clk);
    n_cmp++;
    if (bus_if.press_state !== PRESSED) begin
      n_err++;
      $display("FAIL long_state_before_fire: observed %0d, required 1", bus_if.press_state);
    end
    wait_cyc(n + LAT + LONG);
    @(negedge clk);
    n_cmp++;
    if (bus_if.press_state !== LONG_FIRED) begin
      n_err++;
      $display("FAIL long_state_2: observed %0d, required 2", bus_if.press_state);
    end
    wait_cyc(n + 100);
    r = cyc;
    bus_if.btn_power_menu = 1'b0;
    wait_cyc(r + LAT - 1);
    @(negedge clk);
    n_cmp++;
    if (bus_if.press_state !== LONG_FIRED) begin
      n_err++;
      $display("FAIL long_state_held_to_release: observed %0d, required 2", bus_if.press_state);
    end
    wait_cyc(r + LAT);
    @(negedge clk);
    n_cmp++;
    if (bus_if.press_state !== IDLE) begin
      n_err++;
      $display("FAIL long_state_0: observed %0d, required 0", bus_if.press_state);
    end
    step(10);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL long_press missing: observed %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_press();
    int n;
    int m;
    n = cyc;
    bus_if.btn_power_menu = 1'b1;
    bus_if.btn_third      = 1'b1;
    push(S_THIRD, n + LAT);
    wait_cyc(n + 10);
    @(negedge clk);
    n_cmp++;
    if (bus_if.press_state !== PRESSED) begin
      n_err++;
      $display("FAIL midreset_pre_state: observed %0d, required 1", bus_if.press_state);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pulses() !== 6'b0 || bus_if.press_state !== IDLE) begin
      n_err++;
      $display("FAIL midreset_outputs: observed pulses %b state %0d, required 000000 state 0",
               pulses(), bus_if.press_state);
    end
    step(1);
    bus_if.btn_power_menu = 1'b0;
    step(1);
    m = cyc;
    rst_n = 1'b1;
    push(S_THIRD, m + LAT);
    step(15);
    bus_if.btn_third = 1'b0;
    step(12);
    @(negedge clk);
    n_cmp++;
    if (bus_if.press_state !== IDLE || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL midreset_after: observed state %0d pending %0d, required state 0 pending 0",
               bus_if.press_state, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_lockout();
    int n;
    int t;
    int r;
    n = cyc;
    bus_if.btn_power_menu = 1'b1;
    wait_cyc(n + LAT + 1);
    t = cyc;
    bus_if.btn_third = 1'b1;
`ifndef BUTTON_LEVEL_LOCKOUT_EN
    push(S_THIRD, t + LAT);
`endif
    wait_cyc(n + 10);
    r = cyc;
    bus_if.btn_power_menu = 1'b0;
    push(S_SHORT, r + LAT);
    step(2);
    bus_if.btn_third = 1'b0;
    step(20);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL lockout missing: observed %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = cyc;
    bus_if.btn_first      = 1'b1;
    bus_if.btn_self_clean = 1'b1;
    push(S_FIRST, n + LAT);
    push(S_SELF,  n + LAT);
    step(10);
    bus_if.btn_first      = 1'b0;
    bus_if.btn_self_clean = 1'b0;
    step(10);
    n = cyc;
    bus_if.btn_first = 1'b1;
    push(S_FIRST, n + LAT);
    step(10);
    bus_if.btn_first = 1'b0;
    step(12);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL back_to_back missing: observed %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    cyc   = 0;
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_first_press();
    test_bounce();
    test_short_press();
    test_long_press();
    test_reset_mid_press();
    test_lockout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_button_press_decoder
`default_nettype wire
